// File: rtl/parking_pkg.sv
// Shared parking-meter denominations, used by both the coin-acceptance and the
// coin-refund paths so the two directions always agree on coin values.
package parking_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    NICKEL  = 2'b01,
    DIME    = 2'b10,
    QUARTER = 2'b11
  } coin_e;

  localparam logic [6:0] NICKEL_VAL  = 7'd5;
  localparam logic [6:0] DIME_VAL    = 7'd10;
  localparam logic [6:0] QUARTER_VAL = 7'd25;

  localparam int MAX_TIME_DEFAULT = 99;

  function automatic logic [6:0] coin_value(input coin_e coin);
    logic [6:0] value;
    case (coin)
      NICKEL:  value = NICKEL_VAL;
      DIME:    value = DIME_VAL;
      QUARTER: value = QUARTER_VAL;
      default: value = 7'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational greedy picker: largest coin not exceeding the balance.
// REFUND_ROUNDUP_EN: a 1..4 s remainder is paid out as one extra nickel.
module coin_select
  import parking_pkg::*;
(
  input  logic [6:0] balance_i,
  output coin_e      coin_o,
  output logic [6:0] value_o
);

  always_comb begin
    coin_o = NONE;
    if (balance_i >= QUARTER_VAL) begin
      coin_o = QUARTER;
    end else if (balance_i >= DIME_VAL) begin
      coin_o = DIME;
    end else if (balance_i >= NICKEL_VAL) begin
      coin_o = NICKEL;
`ifdef REFUND_ROUNDUP_EN
    end else if (balance_i != 7'd0) begin
      coin_o = NICKEL;
`endif
    end
    value_o = coin_value(coin_o);
  end

endmodule

// File: rtl/coin_refund_dispenser.sv
// Refunds the unexpired meter balance as a greedy sequence of coin ejects.
// Build option REFUND_ROUNDUP_EN rounds a 1..4 s remainder up to one nickel.
module coin_refund_dispenser
  import parking_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int MAX_TIME   = MAX_TIME_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refund_req,
  input  logic [7:0] time_in,
  input  logic       coin_ready,
  output logic       coin_valid,
  output logic [1:0] coin_type,
  output logic       clear_time,
  output logic       busy,
  output logic       done,
  output logic [2:0] coin_count,
  output logic [2:0] residual
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SELECT   = 3'd1;
  localparam logic [2:0] S_DISPENSE = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [7:0] MAX_TIME_L = 8'(MAX_TIME);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [6:0] balance_q, balance_d;
  coin_e      coin_q, coin_d;
  logic [2:0] count_q, count_d;
  logic [2:0] residual_q, residual_d;
  logic       clear_q, clear_d;
  logic [7:0] gap_q, gap_d;

  coin_e      sel_coin;
  logic [6:0] sel_value;

  coin_select u_coin_select (
    .balance_i (balance_q),
    .coin_o    (sel_coin),
    .value_o   (sel_value)
  );

  // Handshake: a coin moves on a rising edge where coin_valid && coin_ready.
  // coin_valid never drops and coin_type never changes until that edge.
  always_comb begin
    state_d    = state_q;
    balance_d  = balance_q;
    coin_d     = coin_q;
    count_d    = count_q;
    residual_d = residual_q;
    clear_d    = 1'b0;
    gap_d      = gap_q;
    case (state_q)
      S_IDLE: begin
        if (refund_req) begin
          balance_d  = (time_in > MAX_TIME_L) ? MAX_TIME_L[6:0] : time_in[6:0];
          count_d    = 3'd0;
          residual_d = 3'd0;
          clear_d    = 1'b1;
          state_d    = S_SELECT;
        end
      end
      S_SELECT: begin
        if (sel_coin == NONE) begin
          residual_d = balance_q[2:0];
          coin_d     = NONE;
          state_d    = S_DONE;
        end else begin
          coin_d  = sel_coin;
          state_d = S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        if (coin_ready) begin
          // Saturate so a round-up nickel on a 1..4 s balance lands on zero.
          balance_d = (balance_q >= sel_value) ? (balance_q - sel_value) : 7'd0;
          count_d   = count_q + 3'd1;
          coin_d    = NONE;
          gap_d     = 8'd0;
          state_d   = (GAP_CYCLES > 0) ? S_GAP : S_SELECT;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_SELECT;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      balance_q  <= 7'd0;
      coin_q     <= NONE;
      count_q    <= 3'd0;
      residual_q <= 3'd0;
      clear_q    <= 1'b0;
      gap_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      balance_q  <= balance_d;
      coin_q     <= coin_d;
      count_q    <= count_d;
      residual_q <= residual_d;
      clear_q    <= clear_d;
      gap_q      <= gap_d;
    end
  end

  assign coin_valid = (state_q == S_DISPENSE);
  assign coin_type  = coin_q;
  assign clear_time = clear_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign coin_count = count_q;
  assign residual   = residual_q;

endmodule

// File: tb/tb_coin_refund_dispenser.sv
// Self-checking bench for coin_refund_dispenser (GAP_CYCLES=2).
module tb_coin_refund_dispenser;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       refund_req;
  logic [7:0] time_in;
  logic       coin_ready;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       clear_time;
  logic       busy;
  logic       done;
  logic [2:0] coin_count;
  logic [2:0] residual;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_coin;
  int exp_count;
  int exp_res;
  int clear_seen = 0;
  int xfer_seen = 0;

  coin_refund_dispenser #(.GAP_CYCLES(GAP), .MAX_TIME(99)) dut (
    .clk        (clk),
    .reset      (reset),
    .refund_req (refund_req),
    .time_in    (time_in),
    .coin_ready (coin_ready),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .clear_time (clear_time),
    .busy       (busy),
    .done       (done),
    .coin_count (coin_count),
    .residual   (residual)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (clear_time === 1'b1) clear_seen++;
      if (coin_valid === 1'b1 && coin_ready === 1'b1) begin
        xfer_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_coin: got type %0b, expected no coin", coin_type);
        end else begin
          exp_coin = exp_q.pop_front();
          if (coin_type !== exp_coin) begin
            errors++;
            $display("FAIL coin_type: got %0b, expected %0b", coin_type, exp_coin);
          end
        end
      end
    end
  end

  // ---------------- model / driver tasks ----------------
  task automatic push_expected(input int t);
    int b;
    b = (t > 99) ? 99 : t;
    exp_count = 0;
    while (b >= 5) begin
      if (b >= 25) begin exp_q.push_back(2'b11); b -= 25; end
      else if (b >= 10) begin exp_q.push_back(2'b10); b -= 10; end
      else begin exp_q.push_back(2'b01); b -= 5; end
      exp_count++;
    end
`ifdef REFUND_ROUNDUP_EN
    if (b > 0) begin
      exp_q.push_back(2'b01);
      exp_count++;
      b = 0;
    end
`endif
    exp_res = b;
  endtask

  // Returns in cycle N+1 (#1 after edge N, where the request was sampled).
  task automatic start_refund(input int t);
    @(posedge clk); #1;
    refund_req = 1'b1;
    time_in    = 8'(t);
    push_expected(t);
    @(posedge clk); #1;
    refund_req = 1'b0;
    time_in    = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset      = 1'b0;
    refund_req = 1'b0;
    time_in    = 8'd0;
    coin_ready = 1'b0;
    #12;
    checks += 7;
    if (coin_valid !== 1'b0) begin errors++; $display("FAIL reset_coin_valid: got %b, expected 0", coin_valid); end
    if (coin_type !== 2'b00) begin errors++; $display("FAIL reset_coin_type: got %b, expected 00", coin_type); end
    if (clear_time !== 1'b0) begin errors++; $display("FAIL reset_clear_time: got %b, expected 0", clear_time); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
    if (coin_count !== 3'd0) begin errors++; $display("FAIL reset_coin_count: got %0d, expected 0", coin_count); end
    if (residual !== 3'd0) begin errors++; $display("FAIL reset_residual: got %0d, expected 0", residual); end
    @(posedge clk); #3;
    reset = 1'b1;
  endtask

  task automatic test_greedy(input int t);
    int c0, x0, cyc;
    bit ok;
    coin_ready = 1'b1;
    c0 = clear_seen;
    x0 = xfer_seen;
    start_refund(t);
    checks += 2;
    if (clear_time !== 1'b1) begin errors++; $display("FAIL greedy_clear_n1 t=%0d: got %b, expected 1", t, clear_time); end
    if (busy !== 1'b1) begin errors++; $display("FAIL greedy_busy_n1 t=%0d: got %b, expected 1", t, busy); end
    wait_done(cyc, ok);
    checks += 6;
    if (!ok) begin errors++; $display("FAIL greedy_timeout t=%0d: no done within budget, expected done", t); end
    if (cyc != 1 + exp_count * (GAP + 2)) begin errors++; $display("FAIL greedy_latency t=%0d: got %0d cycles, expected %0d", t, cyc, 1 + exp_count * (GAP + 2)); end
    if (coin_count !== 3'(exp_count)) begin errors++; $display("FAIL greedy_count t=%0d: got %0d, expected %0d", t, coin_count, exp_count); end
    if (residual !== 3'(exp_res)) begin errors++; $display("FAIL greedy_residual t=%0d: got %0d, expected %0d", t, residual, exp_res); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL greedy_missing t=%0d: got %0d coins outstanding, expected 0", t, exp_q.size()); end
    if (xfer_seen - x0 != exp_count) begin errors++; $display("FAIL greedy_xfers t=%0d: got %0d, expected %0d", t, xfer_seen - x0, exp_count); end
    @(posedge clk); #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL greedy_busy_after t=%0d: got %b, expected 0", t, busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL greedy_done_width t=%0d: got %b, expected 0", t, done); end
    if (clear_seen - c0 != 1) begin errors++; $display("FAIL greedy_clear_count t=%0d: got %0d, expected 1", t, clear_seen - c0); end
    exp_q.delete();
  endtask

  task automatic test_zero();
    int c0, x0;
    coin_ready = 1'b1;
    c0 = clear_seen;
    x0 = xfer_seen;
    start_refund(0);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_n1: got %b, expected 1", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_n1: got %b, expected 0", done); end
    @(posedge clk); #1;
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done_n2: got %b, expected 1", done); end
    if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_n2: got %b, expected 1", busy); end
    if (coin_valid !== 1'b0) begin errors++; $display("FAIL zero_valid_n2: got %b, expected 0", coin_valid); end
    @(posedge clk); #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_n3: got %b, expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_n3: got %b, expected 0", done); end
    if (xfer_seen != x0) begin errors++; $display("FAIL zero_xfers: got %0d, expected 0", xfer_seen - x0); end
    if (clear_seen - c0 != 1) begin errors++; $display("FAIL zero_clear_count: got %0d, expected 1", clear_seen - c0); end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    coin_ready = 1'b0;
    start_refund(25);
    checks++;
    if (coin_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_n1: got %b, expected 0", coin_valid); end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      checks += 3;
      if (coin_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d: got %b, expected 1", i, coin_valid); end
      if (coin_type !== 2'b11) begin errors++; $display("FAIL bp_hold_type cycle %0d: got %b, expected 11", i, coin_type); end
      if (coin_count !== 3'd0) begin errors++; $display("FAIL bp_hold_count cycle %0d: got %0d, expected 0", i, coin_count); end
      @(posedge clk); #1;
    end
    coin_ready = 1'b1;
    wait_done(cyc, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL bp_timeout: no done within budget, expected done"); end
    if (coin_count !== 3'd1) begin errors++; $display("FAIL bp_count: got %0d, expected 1", coin_count); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_missing: got %0d outstanding, expected 0", exp_q.size()); end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_busy();
    int c0, cyc;
    bit ok;
    coin_ready = 1'b1;
    c0 = clear_seen;
    start_refund(200);
    @(posedge clk); #1;
    refund_req = 1'b1;
    time_in    = 8'd40;
    @(posedge clk); #1;
    refund_req = 1'b0;
    wait_done(cyc, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL busyreq_timeout: no done within budget, expected done"); end
    if (coin_count !== 3'(exp_count)) begin errors++; $display("FAIL busyreq_count: got %0d, expected %0d", coin_count, exp_count); end
    if (residual !== 3'(exp_res)) begin errors++; $display("FAIL busyreq_residual: got %0d, expected %0d", residual, exp_res); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL busyreq_missing: got %0d outstanding, expected 0", exp_q.size()); end
    repeat (6) begin @(posedge clk); #1; end
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL busyreq_queued: busy got %b, expected 0", busy); end
    if (clear_seen - c0 != 1) begin errors++; $display("FAIL busyreq_clear_count: got %0d, expected 1", clear_seen - c0); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit found;
    coin_ready = 1'b1;
    start_refund(40);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (coin_valid === 1'b1 && coin_count === 3'd1) begin
        found = 1'b1;
        break;
      end
    end
    coin_ready = 1'b0;
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_second_coin: not reached, expected valid with count 1"); end
    #2;
    reset = 1'b0;
    #1;
    checks += 4;
    if (coin_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, expected 0", coin_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
    if (coin_count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d, expected 0", coin_count); end
    if (coin_type !== 2'b00) begin errors++; $display("FAIL rstmid_type: got %b, expected 00", coin_type); end
    exp_q.delete();
    coin_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_busy: got %b, expected 0", busy); end
      if (coin_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle_valid: got %b, expected 0", coin_valid); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_greedy(40);
    test_greedy(99);
    test_zero();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid();
    test_greedy(40);
    test_greedy(5);
    test_greedy(4);
    for (int i = 0; i < 4; i++) begin
      test_greedy(int'($urandom_range(0, 255)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
